// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the 5-stage MIPS pipeline.
// Holds the PC, addresses async-read imem, and resolves redirects coming back from ID.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        is_jump,
  input  logic [31:0] j_next_pc,
  input  logic        is_branch,
  input  logic        flush,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  output logic [31:0] pc,
  output logic [31:0] fetch_count,
  output logic [15:0] flush_count
);

  // Control modes, decoded each cycle from the inputs (no stored state):
  //   mode          | meaning
  //   MODE_RESET    | rst_n low, every register reloads its reset value
  //   MODE_STALL    | hazard stall, PC and IF/ID hold, redirects ignored
  //   MODE_REDIRECT | jump or taken branch steers the PC
  //   MODE_RUN      | sequential fetch, PC advances by 4
  typedef enum logic [1:0] {
    MODE_RESET,
    MODE_RUN,
    MODE_STALL,
    MODE_REDIRECT
  } modeT;

  modeT        mode;
  logic [31:0] pcReg;
  logic [31:0] idInstReg;
  logic [31:0] idPcPlus4Reg;
  logic        idValidReg;
  logic [31:0] fetchCountReg;
  logic [15:0] flushCountReg;

  logic [31:0] pcPlus4;
  logic [31:0] branchOffset;
  logic [31:0] branchTarget;
  logic [31:0] pcNext;
  logic [31:0] idInstNext;
  logic [31:0] idPcPlus4Next;
  logic        idValidNext;
  logic [31:0] fetchCountNext;
  logic [15:0] flushCountNext;

  assign pcPlus4      = pcReg + 32'd4;
  assign branchOffset = {{14{idInstReg[15]}}, idInstReg[15:0], 2'b00};
  assign branchTarget = idPcPlus4Reg + branchOffset;

  always_comb begin
    mode = MODE_RUN;
    if (!rst_n)                     mode = MODE_RESET;
    else if (stall)                 mode = MODE_STALL;
    else if (is_jump || is_branch)  mode = MODE_REDIRECT;
  end

  always_comb begin
    pcNext         = pcReg;
    idInstNext     = idInstReg;
    idPcPlus4Next  = idPcPlus4Reg;
    idValidNext    = idValidReg;
    fetchCountNext = fetchCountReg;
    flushCountNext = flushCountReg;

    case (mode)
      MODE_RESET, MODE_STALL: begin
        pcNext = pcReg;
      end
      MODE_REDIRECT: begin
        pcNext = is_jump ? j_next_pc : branchTarget;
      end
      default: begin
        pcNext = pcPlus4;
      end
    endcase

    // IF/ID loads in any non-stalled cycle; flush turns the load into a bubble.
    if (mode == MODE_RUN || mode == MODE_REDIRECT) begin
      if (flush) begin
        idInstNext    = NOP_WORD;
        idPcPlus4Next = 32'd0;
        idValidNext   = 1'b0;
        if (flushCountReg != 16'hFFFF) flushCountNext = flushCountReg + 16'd1;
      end else begin
        idInstNext     = imem_rdata;
        idPcPlus4Next  = pcPlus4;
        idValidNext    = 1'b1;
        fetchCountNext = fetchCountReg + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcReg         <= RESET_PC;
      idInstReg     <= NOP_WORD;
      idPcPlus4Reg  <= 32'd0;
      idValidReg    <= 1'b0;
      fetchCountReg <= 32'd0;
      flushCountReg <= 16'd0;
    end else begin
      pcReg         <= pcNext;
      idInstReg     <= idInstNext;
      idPcPlus4Reg  <= idPcPlus4Next;
      idValidReg    <= idValidNext;
      fetchCountReg <= fetchCountNext;
      flushCountReg <= flushCountNext;
    end
  end

  assign imem_addr   = pcReg;
  assign pc          = pcReg;
  assign id_inst     = idInstReg;
  assign id_pc_plus4 = idPcPlus4Reg;
  assign id_valid    = idValidReg;
  assign fetch_count = fetchCountReg;
  assign flush_count = flushCountReg;

endmodule
